pe_datapath_1d: RTL and testbench

- Clocked datapath end of the 1-D convolution PE.
- Consumes the per-step control tokens (clear, add/split select, filter address, ifmap address) that the PE controller issues.
- Performs the multiply-accumulate into a local accumulator, adds the upstream partial sum, and sends each finished output partial sum downstream.
- Holds local filter and ifmap scratchpads, loaded through a write port.

---
 rtl/pe_datapath_1d.sv | 205 ++++++++++++++++++++
 tb/tb_pe_datapath_1d.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_datapath_1d.sv
// Datapath end of the 1-D convolution PE: filter/ifmap scratchpads, MAC accumulator, psum exchange.
// Define PE_DATAPATH_SAT_EN to saturate the MAC and psum sums (and flag each event on err) instead of wrapping.
module pe_datapath_1d #(
  parameter int WIDTH         = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int FILTER_LENGTH = 3,
  parameter int IFMAP_LENGTH  = 5,
  parameter int ACC_WIDTH     = 20,
  parameter int NUM_OUT       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  input  logic                  ld_sel,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0]      ld_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_clear,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_faddr,
  input  logic [ADDR_WIDTH-1:0] cmd_iaddr,
  input  logic                  psum_in_valid,
  output logic                  psum_in_ready,
  input  logic [ACC_WIDTH-1:0]  psum_in_data,
  output logic                  psum_out_valid,
  input  logic                  psum_out_ready,
  output logic [ACC_WIDTH-1:0]  psum_out_data,
  output logic                  done,
  output logic                  err
);

  localparam int FIDX_W = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1;
  localparam int IIDX_W = (IFMAP_LENGTH > 1) ? $clog2(IFMAP_LENGTH) : 1;
  localparam int CNT_W  = $clog2(NUM_OUT + 1);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_SEND = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t                       state_reg;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic [CNT_W-1:0]             out_count_reg;

  logic signed [WIDTH-1:0]      f_mem [FILTER_LENGTH];
  logic signed [WIDTH-1:0]      i_mem [IFMAP_LENGTH];

  logic                         ld_in_range;
  logic                         faddr_ok;
  logic                         iaddr_ok;
  logic [FIDX_W-1:0]            fidx;
  logic [IIDX_W-1:0]            iidx;
  logic signed [WIDTH-1:0]      f_val;
  logic signed [WIDTH-1:0]      i_val;
  logic signed [2*WIDTH-1:0]    prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  psum_in_s;
  logic signed [ACC_WIDTH-1:0]  mac_res;
  logic signed [ACC_WIDTH-1:0]  sum_res;
  logic                         mac_ovf;
  logic                         sum_ovf;

  assign ld_in_range = ld_sel ? (ld_addr < ADDR_WIDTH'(IFMAP_LENGTH))
                              : (ld_addr < ADDR_WIDTH'(FILTER_LENGTH));

  assign faddr_ok = cmd_faddr < ADDR_WIDTH'(FILTER_LENGTH);
  assign iaddr_ok = cmd_iaddr < ADDR_WIDTH'(IFMAP_LENGTH);
  assign fidx     = cmd_faddr[FIDX_W-1:0];
  assign iidx     = cmd_iaddr[IIDX_W-1:0];
  assign f_val    = faddr_ok ? f_mem[fidx] : '0;
  assign i_val    = iaddr_ok ? i_mem[iidx] : '0;

  // Operands are sign-extended to the product width before multiplying.
  assign prod      = (2*WIDTH)'(f_val) * (2*WIDTH)'(i_val);
  assign prod_ext  = ACC_WIDTH'(prod);
  assign psum_in_s = signed'(psum_in_data);

`ifdef PE_DATAPATH_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] mac_wide;
  logic signed [ACC_WIDTH:0] sum_wide;

  function automatic logic signed [ACC_WIDTH-1:0] clamp(input logic signed [ACC_WIDTH:0] v);
    if (v[ACC_WIDTH] != v[ACC_WIDTH-1])
      return v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    return v[ACC_WIDTH-1:0];
  endfunction

  assign mac_wide = (ACC_WIDTH+1)'(acc_reg) + (ACC_WIDTH+1)'(prod_ext);
  assign sum_wide = (ACC_WIDTH+1)'(acc_reg) + (ACC_WIDTH+1)'(psum_in_s);
  assign mac_ovf  = mac_wide[ACC_WIDTH] ^ mac_wide[ACC_WIDTH-1];
  assign sum_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
  assign mac_res  = clamp(mac_wide);
  assign sum_res  = clamp(sum_wide);
`else
  assign mac_res = acc_reg + prod_ext;
  assign sum_res = acc_reg + psum_in_s;
  assign mac_ovf = 1'b0;
  assign sum_ovf = 1'b0;
`endif

  // Scratchpad writes land at the edge, so a MAC in the same cycle still reads the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FILTER_LENGTH; k++) f_mem[k] <= '0;
      for (int k = 0; k < IFMAP_LENGTH; k++)  i_mem[k] <= '0;
    end else if (ld_valid && ld_in_range) begin
      if (ld_sel)
        i_mem[ld_addr[IIDX_W-1:0]] <= ld_data;
      else
        f_mem[ld_addr[FIDX_W-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      out_count_reg  <= '0;
      cmd_ready      <= 1'b0;
      psum_in_ready  <= 1'b0;
      psum_out_valid <= 1'b0;
      psum_out_data  <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld_valid && !ld_in_range)
        err <= 1'b1;

      case (state_reg)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            if (cmd_clear) begin
              acc_reg <= '0;
            end else begin
              case (cmd_op)
                OP_MAC: begin
                  if (faddr_ok && iaddr_ok) begin
                    acc_reg <= mac_res;
                    if (mac_ovf)
                      err <= 1'b1;
                  end else begin
                    err <= 1'b1;
                  end
                end
                OP_SEND: begin
                  state_reg     <= WAIT_IN;
                  cmd_ready     <= 1'b0;
                  psum_in_ready <= 1'b1;
                end
                OP_ILL:  err <= 1'b1;
                OP_NOP:  ;
                default: ;
              endcase
            end
          end
        end

        // acc is left intact; the controller clears it explicitly for the next output.
        WAIT_IN: begin
          if (psum_in_valid && psum_in_ready) begin
            psum_out_data  <= sum_res;
            psum_out_valid <= 1'b1;
            psum_in_ready  <= 1'b0;
            state_reg      <= SEND;
            if (sum_ovf)
              err <= 1'b1;
          end
        end

        SEND: begin
          if (psum_out_ready) begin
            psum_out_valid <= 1'b0;
            cmd_ready      <= 1'b1;
            state_reg      <= IDLE;
            if (out_count_reg == CNT_W'(NUM_OUT - 1)) begin
              out_count_reg <= '0;
              done          <= 1'b1;
            end else begin
              out_count_reg <= out_count_reg + 1'b1;
            end
          end
        end

        default: begin
          state_reg     <= IDLE;
          cmd_ready     <= 1'b0;
          psum_in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_datapath_1d.sv
// Directed and randomized bench for pe_datapath_1d against a scratchpad/accumulator reference model.
module tb_pe_datapath_1d;

  localparam int WIDTH = 8;
  localparam int AW    = 8;
  localparam int FL    = 3;
  localparam int IL    = 5;
  localparam int ACCW  = 20;
  localparam int NOUT  = 3;
  localparam longint MODV = longint'(1) << ACCW;
  localparam longint MAXV = (longint'(1) << (ACCW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACCW - 1));

  logic            clk;
  logic            rst_n;
  logic            ld_valid;
  logic            ld_sel;
  logic [AW-1:0]   ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_clear;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_faddr;
  logic [AW-1:0]   cmd_iaddr;
  logic            psum_in_valid;
  logic            psum_in_ready;
  logic [ACCW-1:0] psum_in_data;
  logic            psum_out_valid;
  logic            psum_out_ready;
  logic [ACCW-1:0] psum_out_data;
  logic            done;
  logic            err;

  pe_datapath_1d dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear), .cmd_op(cmd_op),
    .cmd_faddr(cmd_faddr), .cmd_iaddr(cmd_iaddr),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .psum_out_data(psum_out_data),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  longint fm [FL];
  longint im [IL];
  longint acc_m;
  int     cnt_m;
  bit     err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic longint fix(input longint v, output bit ovf);
    longint r;
    ovf = 1'b0;
`ifdef PE_DATAPATH_SAT_EN
    if (v > MAXV) begin
      r = MAXV; ovf = 1'b1;
    end else if (v < MINV) begin
      r = MINV; ovf = 1'b1;
    end else begin
      r = v;
    end
`else
    r = v % MODV;
    if (r < 0) r += MODV;
    if (r > MAXV) r -= MODV;
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < FL; k++) fm[k] = 0;
    for (int k = 0; k < IL; k++) im[k] = 0;
    acc_m = 0; cnt_m = 0; err_m = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 0; ld_sel = 0; ld_addr = '0; ld_data = '0;
    cmd_valid = 0; cmd_clear = 0; cmd_op = 2'b00; cmd_faddr = '0; cmd_iaddr = '0;
    psum_in_valid = 0; psum_in_data = '0; psum_out_ready = 0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic wait_cmd_ready();
    for (int k = 0; k < 20 && !cmd_ready; k++) tick();
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic model_load(input bit sel, input int addr, input longint val);
    if (sel ? (addr < IL) : (addr < FL)) begin
      if (sel) im[addr] = val; else fm[addr] = val;
    end else begin
      err_m = 1'b1;
    end
  endtask

  task automatic load(input bit sel, input int addr, input int val);
    logic [WIDTH-1:0] d;
    d = val[WIDTH-1:0];
    ld_valid = 1; ld_sel = sel; ld_addr = addr[AW-1:0]; ld_data = d;
    tick();
    ld_valid = 0;
    model_load(sel, addr, longint'($signed(d)));
  endtask

  task automatic cmd(input bit clr, input logic [1:0] op, input int fa, input int ia,
                     input bit do_ld, input bit sel, input int addr, input int val);
    logic [WIDTH-1:0] d;
    bit ovf;
    d = val[WIDTH-1:0];
    wait_cmd_ready();
    cmd_valid = 1; cmd_clear = clr; cmd_op = op; cmd_faddr = fa[AW-1:0]; cmd_iaddr = ia[AW-1:0];
    ld_valid = do_ld; ld_sel = sel; ld_addr = addr[AW-1:0]; ld_data = d;
    tick();
    cmd_valid = 0; cmd_clear = 0; cmd_op = 2'b00; ld_valid = 0;
    if (clr) acc_m = 0;
    else if (op == 2'b01) begin
      if (fa < FL && ia < IL) begin
        acc_m = fix(acc_m + fm[fa] * im[ia], ovf);
        if (ovf) err_m = 1'b1;
      end else err_m = 1'b1;
    end else if (op == 2'b11) err_m = 1'b1;
    if (do_ld) model_load(sel, addr, longint'($signed(d)));
  endtask

  task automatic mac(input int fa, input int ia);
    cmd(0, 2'b01, fa, ia, 0, 0, 0, 0);
  endtask

  task automatic clear_acc();
    cmd(1, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic start_exchange(input longint pin, output logic [ACCW-1:0] e);
    bit ovf;
    longint s;
    wait_cmd_ready();
    cmd_valid = 1; cmd_clear = 0; cmd_op = 2'b10;
    tick();
    cmd_valid = 0; cmd_op = 2'b00;
    for (int k = 0; k < 20 && !psum_in_ready; k++) tick();
    chk("psum_in_ready", psum_in_ready, 1);
    psum_in_valid = 1; psum_in_data = pin[ACCW-1:0];
    tick();
    psum_in_valid = 0;
    s = fix(acc_m + pin, ovf);
    if (ovf) err_m = 1'b1;
    e = s[ACCW-1:0];
    chk("psum_out_valid_rise", psum_out_valid, 1);
    chk("psum_out_data", psum_out_data, e);
    chk("cmd_ready_in_send", cmd_ready, 0);
    chk("psum_in_ready_in_send", psum_in_ready, 0);
  endtask

  task automatic exchange(input longint pin, input int hold);
    logic [ACCW-1:0] e;
    start_exchange(pin, e);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("bp_valid_hold", psum_out_valid, 1);
      chk("bp_data_hold", psum_out_data, e);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    psum_out_ready = 1;
    tick();
    psum_out_ready = 0;
    chk("psum_out_valid_fall", psum_out_valid, 0);
    cnt_m++;
    if (cnt_m == NOUT) begin
      cnt_m = 0;
      chk("done_pulse", done, 1);
      tick();
      chk("done_width", done, 0);
    end else begin
      chk("done_quiet", done, 0);
    end
    chk("err_flag", err, err_m);
    $display("psum exchange: psum_in=%0d psum_out=%0d expected=%0d", pin, $signed(psum_out_data), $signed(e));
  endtask

  task automatic run_row(input longint p0, input longint p1, input longint p2);
    longint pins [3];
    pins[0] = p0; pins[1] = p1; pins[2] = p2;
    for (int i = 0; i < NOUT; i++) begin
      clear_acc();
      for (int j = 0; j < FL; j++) mac(j, i + j);
      exchange(pins[i], 0);
    end
  endtask

  initial begin
    logic [ACCW-1:0] e;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #23;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psum_in_ready", psum_in_ready, 0);
    chk("rst_psum_out_valid", psum_out_valid, 0);
    chk("rst_psum_out_data", psum_out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Baseline row, then chained psums, then backpressure
    for (int k = 0; k < FL; k++) load(0, k, k + 1);
    for (int k = 0; k < IL; k++) load(1, k, k + 1);
    run_row(0, 0, 0);
    chk("err_baseline", err, 0);
    run_row(100, -50, 7);
    clear_acc();
    for (int j = 0; j < FL; j++) mac(j, j);
    exchange(0, 5);

    // Same-cycle load and MAC of one entry: MAC sees the old value
    clear_acc();
    cmd(0, 2'b01, 1, 2, 1, 0, 1, -9);
    cmd(0, 2'b01, 1, 2, 1, 1, 2, 11);
    mac(1, 2);
    exchange(3, 0);

    // Randomized rows
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < FL; k++) load(0, k, int'($urandom_range(0, 255)));
      for (int k = 0; k < IL; k++) load(1, k, int'($urandom_range(0, 255)));
      for (int i = 0; i < NOUT; i++) begin
        clear_acc();
        for (int j = 0; j < 4; j++) mac(int'($urandom_range(0, FL - 1)), int'($urandom_range(0, IL - 1)));
        exchange(longint'(int'($urandom_range(0, 4000))) - 2000, int'($urandom_range(0, 2)));
      end
    end
    chk("err_random", err, err_m);

    // Accumulator overflow
    clear_acc();
    load(0, 0, 127);
    load(1, 0, 127);
    for (int k = 0; k < 33; k++) mac(0, 0);
    exchange(0, 0);
    chk("err_overflow", err, err_m);

    // Error cases, each from a fresh reset
    pulse_reset();
    chk("err_cleared", err, 0);
    cmd(0, 2'b11, 0, 0, 0, 0, 0, 0);
    chk("err_illegal_op", err, 1);

    pulse_reset();
    for (int k = 0; k < FL; k++) load(0, k, k + 2);
    for (int k = 0; k < IL; k++) load(1, k, k + 3);
    chk("err_before_bad_load", err, 0);
    load(1, 7, 99);
    chk("err_bad_ifmap_load", err, 1);
    load(0, 4, 77);
    clear_acc();
    mac(0, 0);
    mac(0, 2);
    exchange(0, 0);

    pulse_reset();
    for (int k = 0; k < FL; k++) load(0, k, k + 1);
    for (int k = 0; k < IL; k++) load(1, k, k + 1);
    clear_acc();
    mac(2, 4);
    chk("err_before_bad_mac", err, 0);
    mac(5, 0);
    chk("err_bad_faddr", err, 1);
    exchange(0, 0);

    // Reset while a psum is waiting downstream
    pulse_reset();
    for (int k = 0; k < FL; k++) load(0, k, 3);
    for (int k = 0; k < IL; k++) load(1, k, 4);
    clear_acc();
    mac(0, 0);
    exchange(1, 0);
    mac(1, 1);
    start_exchange(5, e);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_drop", psum_out_valid, 0);
    chk("midrst_data_zero", psum_out_data, 0);
    chk("midrst_done", done, 0);
    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    tick();
    chk("postrst_done", done, 0);
    chk("postrst_cmd_ready", cmd_ready, 1);
    mac(0, 0);
    exchange(0, 0);
    exchange(-4, 0);
    exchange(6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
